pipe_buf_stage: RTL and testbench
=================================

// Module: pipe_buf_stage
// PURPOSE
//  Parametrised elastic pipeline buffer between two RISC-V pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries one packed stage struct per entry, with valid/ready handshake, flush and DEPTH-entry buffering.
//  Supplies a bubble (all-zero control/payload) whenever empty, so stalls and flushes need no per-field logic.
//  Next generation of the fixed per-stage buffer registers; one instance per stage boundary.
// PARAMETERS
//  WIDTH   64   payload bits ($bits of the stage struct carried); >=1
//  DEPTH   2    buffer entries; >=1; need not be a power of two
//  CNT_W   $clog2(DEPTH+1)  occupancy width; derived, do not override
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high; clears all state
//  flush      in   1       discard all entries this cycle (branch/jump redirect)
//  in_valid   in   1       upstream stage presents in_data
//  in_ready   out  1       buffer accepts in_data this cycle
//  in_data    in   WIDTH   upstream stage payload
//  out_valid  out  1       out_data holds a real entry
//  out_ready  in   1       downstream consumes head (0 = stall)
//  out_data   out  WIDTH   head entry; all-zero bubble when !out_valid
//  count      out  CNT_W   current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset: count=0, rd_ptr=wr_ptr=0, out_valid=0, out_data=0, in_ready=1. Storage contents need not be cleared.
//  - push = in_valid & in_ready & !flush; pop = out_valid & out_ready & !flush.
//  - in_ready = (count < DEPTH). Registered state only; no combinational path from out_ready.
//    Consequence: when full, a same-cycle pop does NOT enable a push; in_ready rises the cycle after the pop.
//  - out_valid = (count != 0); out_data = valid ? mem[rd_ptr] : '0. Both depend on registers only.
//  - Latency: a push into an empty buffer appears on out_data the next cycle (1 cycle, no bypass).
//  - Order strictly FIFO. wr_ptr/rd_ptr advance on push/pop.
//    Each wraps from DEPTH-1 to 0 by explicit compare, not by modulo-2^n.
//  - count update: push&!pop -> +1; pop&!push -> -1; both or neither -> unchanged.
//  - Simultaneous push and pop when 0<count<DEPTH: both occur; count is unchanged and ordering is preserved.
//  - Empty with out_ready=1: no pop, and out_data stays '0.
//  - Full with in_valid=1: no push; in_data is ignored. The upstream stage must hold its data (stall).
//  - flush=1: next cycle count=0, pointers=0, out_valid=0. A push presented in the flush cycle is dropped.
//    A pop in the flush cycle does not count as consumed. flush has priority over push and pop.
//  - reset during operation behaves as flush and additionally dominates flush.
//  - DEPTH=1: a plain stall-able register with throughput 1 entry per 2 cycles when back-pressured.
//    Full throughput needs DEPTH>=2.
//  - Assertions (sim only): no push when count==DEPTH; no pop when count==0; count<=DEPTH.
// STRUCTURE
//  - Shared package pipe_buf_pkg: stage payload widths as localparams, e.g. IF_ID_W=$bits(if_id_reg).
//    Also holds a typedef pb_status_t {count, full, empty} for debug taps.
//    Stage structs stay in the existing pipeline register package.
//  - One sub-module, pipe_buf_ptr: wrap counter (0..DEPTH-1) with inc and clr inputs.
//    Instantiated twice, for wr_ptr and rd_ptr. Storage is an inline reg array; count is inline.
//  - Callers pack/unpack stage structs at the boundary; this block is payload-agnostic.
// TESTING
//  1. Reset, DEPTH=2, WIDTH=64: after reset count=0, in_ready=1, out_valid=0, out_data=0.
//     Hold out_ready=1 for 3 cycles -> no change.
//  2. Push 0xA,0xB,0xC back-to-back with out_ready=0 -> count 1,2; in_ready=0 after 2nd push; 0xC held off.
//     Raise out_ready -> pops 0xA, then 0xB; 0xC is accepted the cycle after in_ready rises.
//  3. Streaming: in_valid=out_ready=1 for 20 cycles, values 1..20.
//     Out sequence is 1..20 at 1/cycle after 1-cycle latency; count stays 1.
//  4. Fill with 0x11,0x22, then flush with in_valid=1 carrying 0x33.
//     Next cycle count=0, out_valid=0, out_data=0; 0x33 is never output.
//  5. DEPTH=3 wrap: push/pop 7 entries 0x1..0x7 with random out_ready (seeded).
//     Output order is 0x1..0x7, and pointers pass 2->0 at least twice.
//  6. Reset asserted with count=2 and flush=1 in the same cycle -> next cycle matches the scenario-1 reset state.

Source files
------------

// File: rtl/pipe_buf_pkg.sv
// Shared definitions for the inter-stage elastic pipeline buffers: stage payload
// widths, a debug status record and the pointer-width helper.
package pipe_buf_pkg;

  // Packed widths of the stage register structs carried by each boundary instance
  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 160;
  localparam int EX_MEM_W = 112;
  localparam int MEM_WB_W = 72;

  localparam int PB_STAT_CNT_W = 8;

  typedef struct packed {
    logic [PB_STAT_CNT_W-1:0] count;
    logic                     full;
    logic                     empty;
  } pb_status_t;

  // A single-entry buffer still needs a one-bit pointer to stay well-formed
  function automatic int pb_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_buf_ptr.sv
// Wrap-around index 0..DEPTH-1 for the buffer read/write pointers; wraps by
// explicit compare so non-power-of-two depths work.
module pipe_buf_ptr
  import pipe_buf_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = pb_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/pipe_buf_stage.sv
// Elastic FIFO buffer between two pipeline stages. Presents an all-zero bubble
// when empty; all outputs come from registers only.
module pipe_buf_stage
  import pipe_buf_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = pb_ptr_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // in_ready deliberately ignores out_ready: no combinational path through the buffer
  assign in_ready  = (r_count < CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[w_rd_ptr] : '0;
  assign count     = r_count;

  assign w_push = in_valid  && in_ready  && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  pipe_buf_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (w_push),
    .ptr   (w_wr_ptr)
  );

  pipe_buf_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (w_pop),
    .ptr   (w_rd_ptr)
  );

  // Storage holds payload only; validity is tracked by r_count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    !(w_push && (r_count == CNT_W'(DEPTH))));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
    !(w_pop && (r_count == '0)));
  a_count_range:  assert property (@(posedge clk) disable iff (reset)
    r_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_pipe_buf_stage.sv
// Scoreboard bench for pipe_buf_stage: a DEPTH=2 and a DEPTH=3 instance share
// the input stimulus; use3 selects which instance the scoreboard observes.
module tb_pipe_buf_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [63:0] in_data;

  logic        rdy2, vld2, rdy3, vld3;
  logic [63:0] dat2, dat3;
  logic [1:0]  cnt2, cnt3;

  logic        in_ready_m, out_valid_m;
  logic [63:0] out_data_m;
  logic [1:0]  count_m;
  logic        use3 = 1'b0;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  bit          last_push;
  int          wr_wraps, rd_wraps;

  always #5 clk = ~clk;

  pipe_buf_stage #(.WIDTH(64), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
    .in_data(in_data), .out_valid(vld2), .out_ready(out_ready), .out_data(dat2), .count(cnt2)
  );

  pipe_buf_stage #(.WIDTH(64), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy3),
    .in_data(in_data), .out_valid(vld3), .out_ready(out_ready), .out_data(dat3), .count(cnt3)
  );

  assign in_ready_m  = use3 ? rdy3 : rdy2;
  assign out_valid_m = use3 ? vld3 : vld2;
  assign out_data_m  = use3 ? dat3 : dat2;
  assign count_m     = use3 ? cnt3 : cnt2;

  // Record handshakes just before the edge, then advance to 1 time unit past it
  task automatic tick();
    logic [1:0] pw, pr;
    last_push = 1'b0;
    if (!reset && !flush) begin
      if (in_valid && in_ready_m) begin
        exp_q.push_back(in_data);
        last_push = 1'b1;
      end
      if (out_valid_m && out_ready) got_q.push_back(out_data_m);
    end
    pw = dut3.w_wr_ptr;
    pr = dut3.w_rd_ptr;
    @(posedge clk);
    #1;
    if (pw == 2'd2 && dut3.w_wr_ptr == 2'd0) wr_wraps++;
    if (pr == 2'd2 && dut3.w_rd_ptr == 2'd0) rd_wraps++;
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (count_m !== 2'd0) begin errors++; $display("FAIL %s_count got=%0d exp=0", tag, count_m); end
    checks++;
    if (in_ready_m !== 1'b1) begin errors++; $display("FAIL %s_in_ready got=%b exp=1", tag, in_ready_m); end
    checks++;
    if (out_valid_m !== 1'b0) begin errors++; $display("FAIL %s_out_valid got=%b exp=0", tag, out_valid_m); end
    checks++;
    if (out_data_m !== 64'd0) begin errors++; $display("FAIL %s_out_data got=%h exp=0", tag, out_data_m); end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick(); tick();
    reset = 1'b0;
    check_idle("reset");
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("reset_hold");
    end
    out_ready = 1'b0;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA;
    tick();
    checks++;
    if (count_m !== 2'd1 || out_data_m !== 64'hA) begin
      errors++; $display("FAIL bp_first got cnt=%0d data=%h exp cnt=1 data=a", count_m, out_data_m);
    end
    in_data = 64'hB;
    tick();
    checks++;
    if (count_m !== 2'd2 || in_ready_m !== 1'b0) begin
      errors++; $display("FAIL bp_full got cnt=%0d rdy=%b exp cnt=2 rdy=0", count_m, in_ready_m);
    end
    in_data = 64'hC;
    tick();
    checks++;
    if (count_m !== 2'd2 || out_data_m !== 64'hA) begin
      errors++; $display("FAIL bp_hold got cnt=%0d data=%h exp cnt=2 data=a", count_m, out_data_m);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (count_m !== 2'd1 || in_ready_m !== 1'b1 || out_data_m !== 64'hB) begin
      errors++; $display("FAIL bp_pop1 got cnt=%0d rdy=%b data=%h exp cnt=1 rdy=1 data=b", count_m, in_ready_m, out_data_m);
    end
    tick();
    checks++;
    if (count_m !== 2'd1 || out_data_m !== 64'hC) begin
      errors++; $display("FAIL bp_pushpop got cnt=%0d data=%h exp cnt=1 data=c", count_m, out_data_m);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++;
    if (count_m !== 2'd0) begin errors++; $display("FAIL bp_drain got cnt=%0d exp=0", count_m); end
    checks++;
    if (got_q.size() != 3) begin errors++; $display("FAIL bp_outputs got=%0d exp=3", got_q.size()); end
    for (int k = 0; k < 3; k++) begin
      logic [63:0] want;
      want = 64'hA + 64'(k);
      checks++;
      if (k >= got_q.size() || got_q[k] !== want) begin
        errors++; $display("FAIL bp_order[%0d] got=%h exp=%h", k, (k < got_q.size()) ? got_q[k] : 64'hx, want);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_streaming();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      in_data = 64'(i);
      tick();
      checks++;
      if (count_m !== 2'd1 || out_data_m !== 64'(i)) begin
        errors++; $display("FAIL stream[%0d] got cnt=%0d data=%0d exp cnt=1 data=%0d", i, count_m, out_data_m, i);
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++;
    if (got_q.size() != 20 || exp_q.size() != 20) begin
      errors++; $display("FAIL stream_len got=%0d exp=20", got_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k] || exp_q[k] !== 64'(k + 1)) begin
        errors++; $display("FAIL stream_order[%0d] got=%0d exp=%0d", k, (k < got_q.size()) ? got_q[k] : 64'hx, k + 1);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 64'h11; tick();
    in_data = 64'h22; tick();
    checks++;
    if (count_m !== 2'd2) begin errors++; $display("FAIL flush_fill got cnt=%0d exp=2", count_m); end
    flush = 1'b1; in_data = 64'h33;
    tick();
    exp_q.delete();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (count_m !== 2'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count_m); end
    checks++;
    if (out_valid_m !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid_m); end
    checks++;
    if (out_data_m !== 64'd0) begin errors++; $display("FAIL flush_data got=%h exp=0", out_data_m); end
    in_valid = 1'b1; in_data = 64'h44;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL flush_outputs got=%0d exp=1", got_q.size()); end
    checks++;
    if (got_q.size() < 1 || got_q[0] !== 64'h44) begin
      errors++; $display("FAIL flush_after got=%h exp=44", (got_q.size() > 0) ? got_q[0] : 64'hx);
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_wrap();
    int pushed, cycles;
    use3 = 1'b1;
    reset = 1'b1; tick(); reset = 1'b0;
    exp_q.delete(); got_q.delete();
    wr_wraps = 0; rd_wraps = 0; pushed = 0; cycles = 0;
    void'($urandom(32'd77));
    while (got_q.size() < 7 && cycles < 300) begin
      in_valid  = (pushed < 7);
      in_data   = 64'(pushed + 1);
      out_ready = 1'($urandom_range(0, 1));
      tick();
      if (last_push) pushed++;
      cycles++;
      checks++;
      if (count_m > 2'd3) begin errors++; $display("FAIL wrap_count got=%0d exp<=3", count_m); end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (cycles >= 300) begin errors++; $display("FAIL wrap_timeout got=%0d outputs exp=7", got_q.size()); end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (k >= got_q.size() || got_q[k] !== 64'(k + 1)) begin
        errors++; $display("FAIL wrap_order[%0d] got=%h exp=%h", k, (k < got_q.size()) ? got_q[k] : 64'hx, k + 1);
      end
    end
    checks++;
    if (wr_wraps < 2) begin errors++; $display("FAIL wrap_wr got=%0d exp>=2", wr_wraps); end
    checks++;
    if (rd_wraps < 2) begin errors++; $display("FAIL wrap_rd got=%0d exp>=2", rd_wraps); end
    use3 = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 64'h5; tick();
    in_data = 64'h6; tick();
    checks++;
    if (count_m !== 2'd2) begin errors++; $display("FAIL rstfl_fill got cnt=%0d exp=2", count_m); end
    reset = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check_idle("rstfl");
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_backpressure();
    test_streaming();
    test_flush();
    test_wrap();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
